// File: rtl/tb_doutb_seq.sv
// TB port-B read sequencer: issues BRAM reads and drives mapper controls delayed RD_LAT cycles to meet read data.
// map_valid trails issue by RD_LAT+1; one command at a time, cmd_ready low while busy (no queuing).
module tb_doutb_seq #(
  parameter int TB_AW      = 10,
  parameter int LEN_W      = 6,
  parameter int RD_LAT     = 1,
  parameter int SEQ_CNT_DW = 5
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [TB_AW-1:0]      cmd_base,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_lk0,
  output logic                  TB_enb,
  output logic [TB_AW-1:0]      TB_addrb,
  output logic [2:0]            TB_doutb_sel,
  output logic                  l_k_0,
  output logic [SEQ_CNT_DW-1:0] seq_cnt_dout_sel,
  output logic                  map_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic                  vld;
    logic [2:0]            op;
    logic                  lk0;
    logic [SEQ_CNT_DW-1:0] idx;
    logic                  last;
  } stage_t;

  state_t               state_q, state_d;
  logic                 enb_q, enb_d;
  logic [TB_AW-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [LEN_W-1:0]     last_beat_q, last_beat_d;
  logic [2:0]           op_q, op_d;
  logic                 lk0_q, lk0_d;
  logic                 map_valid_q, map_valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [LEN_W-1:0]     n_beats;
  stage_t               pipe_q [1:RD_LAT];
  stage_t               pipe_d [1:RD_LAT];
  stage_t               stg    [0:RD_LAT];

  always_comb begin
    n_beats = cmd_len;
    if (cmd_op[1:0] == 2'b00) begin
      n_beats = '0;
    end else if (cmd_op[2] && cmd_op[1]) begin
      n_beats = LEN_W'(8);
    end
  end

  // stg[0] is the issue stage; invalid stages carry zero sel/index, lk0 holds its last beat value.
  always_comb begin
    stg[0].vld  = enb_q;
    stg[0].op   = enb_q ? op_q : 3'b000;
    stg[0].lk0  = lk0_q;
    stg[0].idx  = enb_q ? SEQ_CNT_DW'(beat_q) : '0;
    stg[0].last = enb_q && (beat_q == last_beat_q);
    for (int i = 1; i <= RD_LAT; i++) begin
      stg[i]         = pipe_q[i];
      pipe_d[i]      = stg[i-1];
      pipe_d[i].lk0  = stg[i-1].vld ? stg[i-1].lk0 : pipe_q[i].lk0;
    end
  end

  always_comb begin
    state_d     = state_q;
    enb_d       = enb_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    op_d        = op_q;
    lk0_d       = lk0_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    map_valid_d = stg[RD_LAT].vld;
    done_d      = stg[RD_LAT].last;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (n_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            enb_d       = 1'b1;
            addr_d      = cmd_base;
            beat_d      = '0;
            last_beat_d = n_beats - LEN_W'(1);
            op_d        = cmd_op;
            lk0_d       = cmd_lk0;
            busy_d      = 1'b1;
            ready_d     = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (beat_q == last_beat_q) begin
          state_d = DRAIN;
          enb_d   = 1'b0;
        end else begin
          beat_d = beat_q + LEN_W'(1);
          addr_d = addr_q + TB_AW'(1);
        end
      end
      DRAIN: begin
        // Leave one cycle early so done, busy=0 and cmd_ready=1 coincide.
        if (stg[RD_LAT].last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      enb_q       <= 1'b0;
      addr_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      op_q        <= 3'b000;
      lk0_q       <= 1'b0;
      map_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      enb_q       <= enb_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      op_q        <= op_d;
      lk0_q       <= lk0_d;
      map_valid_q <= map_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign cmd_ready        = ready_q;
  assign TB_enb           = enb_q;
  assign TB_addrb         = addr_q;
  assign TB_doutb_sel     = pipe_q[RD_LAT].op;
  assign l_k_0            = pipe_q[RD_LAT].lk0;
  assign seq_cnt_dout_sel = pipe_q[RD_LAT].idx;
  assign map_valid        = map_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_tb_doutb_seq.sv
// Directed bench for tb_doutb_seq: instance a uses RD_LAT=1, instance b uses RD_LAT=3.
module tb_tb_doutb_seq;
  logic       clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid, cmd_valid_b;
  logic [2:0] cmd_op;
  logic [9:0] cmd_base;
  logic [5:0] cmd_len;
  logic       cmd_lk0;

  logic       rdy_a, enb_a, lk0_a, mv_a, busy_a, done_a;
  logic [9:0] addr_a;
  logic [2:0] sel_a;
  logic [4:0] seq_a;
  logic       rdy_b, enb_b, lk0_b, mv_b, busy_b, done_b;
  logic [9:0] addr_b;
  logic [2:0] sel_b;
  logic [4:0] seq_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tb_doutb_seq #(.TB_AW(10), .LEN_W(6), .RD_LAT(1), .SEQ_CNT_DW(5)) dut_a (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_a),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_lk0(cmd_lk0),
    .TB_enb(enb_a), .TB_addrb(addr_a), .TB_doutb_sel(sel_a), .l_k_0(lk0_a),
    .seq_cnt_dout_sel(seq_a), .map_valid(mv_a), .busy(busy_a), .done(done_a));

  tb_doutb_seq #(.TB_AW(10), .LEN_W(6), .RD_LAT(3), .SEQ_CNT_DW(5)) dut_b (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid_b), .cmd_ready(rdy_b),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_lk0(cmd_lk0),
    .TB_enb(enb_b), .TB_addrb(addr_b), .TB_doutb_sel(sel_b), .l_k_0(lk0_b),
    .seq_cnt_dout_sel(seq_b), .map_valid(mv_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command (accepted at cycle 0) and checks every output for cycles 1..n+lat+3.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [9:0] base,
                         input logic [5:0] len, input logic lk0, input int n, input bit slow);
    int   lat;
    bit   win, bsy;
    logic o_enb, o_lk0, o_mv, o_busy, o_done, o_rdy;
    logic [9:0] o_addr;
    logic [2:0] o_sel;
    logic [4:0] o_seq;
    lat      = slow ? 3 : 1;
    cmd_op   = op;
    cmd_base = base;
    cmd_len  = len;
    cmd_lk0  = lk0;
    if (slow) cmd_valid_b = 1'b1; else cmd_valid = 1'b1;
    tick();
    cmd_valid   = 1'b0;
    cmd_valid_b = 1'b0;
    for (int c = 1; c <= n + lat + 3; c++) begin
      o_enb  = slow ? enb_b  : enb_a;
      o_addr = slow ? addr_b : addr_a;
      o_sel  = slow ? sel_b  : sel_a;
      o_seq  = slow ? seq_b  : seq_a;
      o_lk0  = slow ? lk0_b  : lk0_a;
      o_mv   = slow ? mv_b   : mv_a;
      o_busy = slow ? busy_b : busy_a;
      o_done = slow ? done_b : done_a;
      o_rdy  = slow ? rdy_b  : rdy_a;
      win = (n > 0) && (c >= 1 + lat) && (c <= n + lat);
      bsy = (n > 0) && (c <= n + lat);
      chk({name, ".enb"}, o_enb, (n > 0) && (c <= n));
      if ((n > 0) && (c <= n)) chk({name, ".addr"}, o_addr, 10'(base + c - 1));
      chk({name, ".sel"}, o_sel, win ? op : 3'b000);
      chk({name, ".seq"}, o_seq, win ? 5'(c - 1 - lat) : 5'd0);
      if (win) chk({name, ".lk0"}, o_lk0, lk0);
      chk({name, ".map_valid"}, o_mv, (n > 0) && (c >= 2 + lat) && (c <= n + 1 + lat));
      chk({name, ".done"}, o_done, c == ((n > 0) ? n + 1 + lat : 1));
      chk({name, ".busy"}, o_busy, bsy);
      chk({name, ".ready"}, o_rdy, !bsy);
      tick();
    end
  endtask

  initial begin
    sys_rst     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_op      = 3'b000;
    cmd_base    = 10'h000;
    cmd_len     = 6'd0;
    cmd_lk0     = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    // Reset state
    chk("rst.ready_a", rdy_a, 1'b1);
    chk("rst.enb_a", enb_a, 1'b0);
    chk("rst.addr_a", addr_a, 10'h000);
    chk("rst.sel_a", sel_a, 3'b000);
    chk("rst.seq_a", seq_a, 5'd0);
    chk("rst.lk0_a", lk0_a, 1'b0);
    chk("rst.mv_a", mv_a, 1'b0);
    chk("rst.busy_a", busy_a, 1'b0);
    chk("rst.done_a", done_a, 1'b0);
    chk("rst.ready_b", rdy_b, 1'b1);
    chk("rst.enb_b", enb_b, 1'b0);
    chk("rst.done_b", done_b, 1'b0);

    run_cmd("b_pos",     3'b001, 10'h010, 6'd4, 1'b0, 4, 1'b0);
    run_cmd("bc_transp", 3'b110, 10'h3FC, 6'd2, 1'b1, 8, 1'b0);
    run_cmd("bc_xfer",   3'b101, 10'h200, 6'd3, 1'b0, 3, 1'b0);
    run_cmd("bc_inv_l3", 3'b111, 10'h005, 6'd0, 1'b1, 8, 1'b1);
    run_cmd("b_new_l3",  3'b011, 10'h3FE, 6'd3, 1'b0, 3, 1'b1);
    run_cmd("zero_neg",  3'b010, 10'h040, 6'd0, 1'b1, 0, 1'b0);
    run_cmd("op_000",    3'b000, 10'h040, 6'd5, 1'b1, 0, 1'b0);

    // Back-to-back: valid held, second accepted in the first command's done cycle
    cmd_op    = 3'b001;
    cmd_base  = 10'h020;
    cmd_len   = 6'd3;
    cmd_lk0   = 1'b0;
    cmd_valid = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      if (c == 6) cmd_valid = 1'b0;
      chk("b2b.enb", enb_a, (c <= 3) || (c >= 6 && c <= 8));
      if (c >= 6 && c <= 8) chk("b2b.addr", addr_a, 10'(10'h020 + c - 6));
      chk("b2b.done", done_a, (c == 5) || (c == 10));
      chk("b2b.ready", rdy_a, (c == 5) || (c >= 10));
      tick();
    end
    repeat (4) tick();

    // Reset during the third beat of a 6-beat command
    cmd_op    = 3'b001;
    cmd_base  = 10'h100;
    cmd_len   = 6'd6;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("abort.beat3_addr", addr_a, 10'h102);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("abort.enb", enb_a, 1'b0);
    chk("abort.sel", sel_a, 3'b000);
    chk("abort.mv", mv_a, 1'b0);
    chk("abort.ready", rdy_a, 1'b1);
    chk("abort.busy", busy_a, 1'b0);
    for (int c = 0; c < 8; c++) begin
      chk("abort.no_done", done_a, 1'b0);
      chk("abort.no_enb", enb_a, 1'b0);
      tick();
    end

    run_cmd("post_abort", 3'b001, 10'h0AA, 6'd2, 1'b1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
